// File: rtl/soc_matrix_sysid_checker.sv
// rtl/soc_matrix_sysid_checker.sv - system-ID / build-timestamp checker gating downstream reset release
// Optional feature macro: SYSID_CHECKER_CAPTURE_EN (exposes captured_id / captured_ts debug ports)
module soc_matrix_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1414777198,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic        sys_release
`ifdef SYSID_CHECKER_CAPTURE_EN
  ,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
`endif
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    EVAL  = 3'd3,
    PASS  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        read_d, addr_d, busy_d, done_d, pass_d;
  logic        id_mm_d, ts_mm_d, tmo_d, rel_d;
  logic [15:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        accept;

  assign accept   = avm_read && !avm_waitrequest;
  assign tcnt_inc = tcnt_q + 16'd1;

`ifdef SYSID_CHECKER_CAPTURE_EN
  assign captured_id = id_q;
  assign captured_ts = ts_q;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next value of every registered output, counter and capture
  always_comb begin
    state_d = state_q;
    read_d  = avm_read;
    addr_d  = avm_address;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    id_mm_d = id_mismatch;
    ts_mm_d = ts_mismatch;
    tmo_d   = timeout;
    rel_d   = sys_release;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    id_d    = id_q;
    ts_d    = ts_q;

    case (state_q)
      IDLE: begin
        state_d = RD_ID;
        read_d  = 1'b1;
        addr_d  = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        id_mm_d = 1'b0;
        ts_mm_d = 1'b0;
        tmo_d   = 1'b0;
        rel_d   = 1'b0;
        tcnt_d  = 16'd0;
      end

      RD_ID, RD_TS: begin
        if (accept) begin
          tcnt_d = 16'd0;
          if (state_q == RD_ID) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
            addr_d  = 1'b1;
          end else begin
            ts_d    = avm_readdata;
            state_d = EVAL;
            read_d  = 1'b0;
          end
        end else if (!avm_read) begin
          // One-cycle gap after a stall timeout: retry from word 0 or give up
          tcnt_d = 16'd0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = RD_ID;
            read_d  = 1'b1;
            addr_d  = 1'b0;
          end else begin
            state_d = FAIL;
            tmo_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            rel_d   = 1'b0;
          end
        end else begin
          // Stalled by waitrequest; drop the strobe once the limit is hit
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TMO_LIMIT) begin
            read_d = 1'b0;
          end
        end
      end

      EVAL: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        tcnt_d = 16'd0;
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
          state_d = PASS;
          pass_d  = 1'b1;
          rel_d   = 1'b1;
        end else begin
          state_d = FAIL;
          pass_d  = 1'b0;
          rel_d   = 1'b0;
          id_mm_d = (id_q != EXPECTED_ID);
          ts_mm_d = (ts_q != EXPECTED_TS);
        end
      end

      PASS, FAIL: begin
        if (recheck) begin
          state_d = IDLE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          id_mm_d = 1'b0;
          ts_mm_d = 1'b0;
          tmo_d   = 1'b0;
          rel_d   = 1'b0;
          tcnt_d  = 16'd0;
          retry_d = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs, timeout/retry counters and captured words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      sys_release <= 1'b0;
      tcnt_q      <= 16'd0;
      retry_q     <= 4'd0;
      id_q        <= 32'd0;
      ts_q        <= 32'd0;
    end else begin
      avm_read    <= read_d;
      avm_address <= addr_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      id_mismatch <= id_mm_d;
      ts_mismatch <= ts_mm_d;
      timeout     <= tmo_d;
      sys_release <= rel_d;
      tcnt_q      <= tcnt_d;
      retry_q     <= retry_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
    end
  end

endmodule

// File: tb/tb_soc_matrix_sysid_checker.sv
// tb/tb_soc_matrix_sysid_checker.sv - directed self-checking bench for soc_matrix_sysid_checker
module tb_soc_matrix_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1414777198;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        recheck;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout, sys_release;
  logic [31:0] w0, w1;
`ifdef SYSID_CHECKER_CAPTURE_EN
  logic [31:0] captured_id, captured_ts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Sysid slave model: word 0 / word 1 selected by address
  assign avm_readdata = avm_address ? w1 : w0;

  soc_matrix_sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(4),
    .MAX_RETRIES(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .recheck(recheck),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy),
    .done(done),
    .pass(pass),
    .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch),
    .timeout(timeout),
    .sys_release(sys_release)
`ifdef SYSID_CHECKER_CAPTURE_EN
    ,
    .captured_id(captured_id),
    .captured_ts(captured_ts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_recheck();
    recheck = 1'b1;
    step();
    recheck = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  initial begin
    logic [14:0] trace;
    int          rd;

    reset_n         = 1'b0;
    recheck         = 1'b0;
    avm_waitrequest = 1'b0;
    w0              = 32'd0;
    w1              = EXP_TS;
    repeat (3) step();
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_release", 32'(sys_release), 32'd0);

    // Matching image, no stall
    reset_n = 1'b1;
    step();
    chk("p1_read0", 32'(avm_read), 32'd1);
    chk("p1_addr0", 32'(avm_address), 32'd0);
    chk("p1_busy", 32'(busy), 32'd1);
    step();
    chk("p1_read1", 32'(avm_read), 32'd1);
    chk("p1_addr1", 32'(avm_address), 32'd1);
    step();
    chk("p1_eval_done", 32'(done), 32'd0);
    chk("p1_eval_read", 32'(avm_read), 32'd0);
    step();
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_pass", 32'(pass), 32'd1);
    chk("p1_release", 32'(sys_release), 32'd1);
    chk("p1_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);

    // Timestamp mismatch only
    w1 = EXP_TS + 32'd1;
    pulse_recheck();
    chk("ts_rel_drop", 32'(sys_release), 32'd0);
    repeat (4) step();
    chk("ts_done", 32'(done), 32'd1);
    chk("ts_pass", 32'(pass), 32'd0);
    chk("ts_mm", 32'(ts_mismatch), 32'd1);
    chk("ts_id_mm", 32'(id_mismatch), 32'd0);
    chk("ts_release", 32'(sys_release), 32'd0);
    rd = 0;
    repeat (10) begin
      step();
      rd += int'(avm_read);
    end
    chk("ts_no_retry", 32'(rd), 32'd0);

    // Both words wrong
    w0 = 32'd5;
    w1 = 32'd7;
    pulse_recheck();
    wait_done(10);
    chk("both_id_mm", 32'(id_mismatch), 32'd1);
    chk("both_ts_mm", 32'(ts_mismatch), 32'd1);
    chk("both_pass", 32'(pass), 32'd0);

    // Stuck waitrequest: three attempts of 4 read cycles plus a 1-cycle gap
    w0 = 32'd0;
    w1 = EXP_TS;
    avm_waitrequest = 1'b1;
    pulse_recheck();
    trace = 15'd0;
    for (int i = 0; i < 15; i++) begin
      step();
      trace = {trace[13:0], avm_read};
    end
    chk("tmo_trace", 32'(trace), 32'(15'b111101111011110));
    step();
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_pass", 32'(pass), 32'd0);
    chk("tmo_release", 32'(sys_release), 32'd0);
    avm_waitrequest = 1'b0;
    pulse_recheck();
    chk("tmo_clear", 32'(timeout), 32'd0);
    wait_done(10);
    chk("tmo_recover_pass", 32'(pass), 32'd1);

    // Recheck from PASS; a recheck during RD_TS is ignored
    pulse_recheck();
    chk("rc_rel_drop", 32'(sys_release), 32'd0);
    step();
    step();
    chk("rc_rdts_addr", 32'(avm_address), 32'd1);
    recheck = 1'b1;
    step();
    recheck = 1'b0;
    chk("rc_busy", 32'(busy), 32'd1);
    step();
    chk("rc_pass", 32'(pass), 32'd1);
    step();
    chk("rc_ignored", 32'(sys_release), 32'd1);

    // Reset while stalled in RD_TS
    pulse_recheck();
    step();
    step();
    avm_waitrequest = 1'b1;
    step();
    chk("mr_read_pre", 32'(avm_read), 32'd1);
    chk("mr_addr_pre", 32'(avm_address), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_read", 32'(avm_read), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    avm_waitrequest = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("mr_restart_read", 32'(avm_read), 32'd1);
    chk("mr_restart_addr", 32'(avm_address), 32'd0);
    wait_done(10);
    chk("mr_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_matrix_sysid_checker.md
Name: soc_matrix_sysid_checker

Overview:
Avalon-MM read master that sequences the system-ID slave once after reset and again on request. It reads word 0 (system ID) and word 1 (build timestamp) and compares them against parameterised expected values. It reports pass or fail with cause, and holds a downstream release signal low until the check passes. The block sits between the reset controller and the rest of the SoC fabric, so peripherals stay parked when the image does not match the hardware.

Parameters:
EXPECTED_ID, 32'd0, value required at slave word 0
EXPECTED_TS, 32'd1414777198, value required at slave word 1
TIMEOUT_CYCLES, 255, max cycles a read may be stalled by waitrequest (1..65535)
MAX_RETRIES, 2, extra full read sequences attempted after a timeout (0..15)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
recheck  in  1  single-cycle pulse; restarts sequence from PASS or FAIL
avm_address  out  1  word select to sysid slave (0 = ID, 1 = timestamp)
avm_read  out  1  read strobe
avm_readdata  in  32  slave read data, valid in accept cycle
avm_waitrequest  in  1  slave stall; tie 0 for combinational slave
busy  out  1  sequence in progress
done  out  1  sequence complete (pass or fail), level
pass  out  1  both words matched, level
id_mismatch  out  1  word 0 differed from EXPECTED_ID
ts_mismatch  out  1  word 1 differed from EXPECTED_TS
timeout  out  1  retries exhausted on stall
sys_release  out  1  downstream reset release; high only in PASS

Behaviour:
- One clock; reset_n is asynchronous and active-low.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, all error flags 0, sys_release=0, retry count 0, timeout counter 0, state IDLE.
- States: IDLE, RD_ID, RD_TS, EVAL, PASS, FAIL.
- IDLE: entered from reset. Moves unconditionally to RD_ID on the first clock after reset deasserts. Clears all result flags and sets busy=1.
- RD_ID: avm_read=1, avm_address=0.
  - Accept occurs when avm_read & !avm_waitrequest. On accept, capture avm_readdata into id_q and go to RD_TS.
  - avm_read stays asserted and address stays stable while waitrequest=1.
- RD_TS: same handshake with avm_address=1. On accept, capture into ts_q and go to EVAL.
- Minimum sequence with waitrequest=0: RD_ID 1 cycle, RD_TS 1 cycle, EVAL 1 cycle. done/pass visible 3 cycles after leaving IDLE.
- EVAL:
  - Compares id_q to EXPECTED_ID and ts_q to EXPECTED_TS, full 32-bit equality.
  - Both equal: go to PASS.
  - Otherwise: set the corresponding mismatch flag(s) and go to FAIL. Both flags may be set together.
  - Mismatch does not retry.
- Timeout counter:
  - 16-bit counter, cleared on every accept and on each state entry.
  - Increments every cycle that avm_read=1 and waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES, deassert avm_read for exactly 1 cycle, then:
    - if retry count < MAX_RETRIES: increment retry count and restart at RD_ID;
    - else: set timeout=1 and go to FAIL.
  - Retry count clears only on IDLE entry or recheck.
- PASS: done=1, pass=1, busy=0, sys_release=1.
- FAIL: done=1, pass=0, busy=0, sys_release=0. Flags hold.
- recheck:
  - In PASS or FAIL: go to IDLE next cycle. sys_release drops immediately, in the same cycle IDLE is entered, and remains low until a new PASS.
  - While busy: ignored.
- Outputs are registered. avm_address changes only on state transitions.
- Reset mid-sequence: all outputs return to reset values asynchronously. The in-flight read is abandoned. The sequence restarts from IDLE after deassertion.

Optional Feature:
SYSID_CHECKER_CAPTURE_EN
- Defined: adds output ports captured_id[31:0] and captured_ts[31:0], driven from id_q/ts_q. Both reset to 0 and update on each accept, for debug readback via a PIO.
- Undefined: ports are absent and id_q/ts_q are not exposed. Comparison behaviour is identical in both cases.

Test Plan:
- waitrequest=0, slave returns 0 then 1414777198 -> avm_read high for addr 0 then addr 1 on consecutive cycles; pass=1, done=1, sys_release=1 on cycle 3 after reset release; flags 0.
- Slave returns 0 then 1414777199 -> FAIL; ts_mismatch=1, id_mismatch=0, sys_release=0, no retry reads issued.
- Slave returns 5 then 7 -> id_mismatch=1 and ts_mismatch=1 together, done=1, pass=0.
- TIMEOUT_CYCLES=4, MAX_RETRIES=2, waitrequest stuck 1 -> three read attempts, each followed by a 1-cycle read gap; then timeout=1, FAIL. Next, release waitrequest and pulse recheck -> PASS.
- In PASS, pulse recheck -> sys_release low the next cycle, full sequence re-runs, PASS again. A recheck pulse during RD_TS is ignored.
- Assert reset_n low while in RD_TS with waitrequest=1 -> avm_read=0 and busy=0 immediately; after release, the sequence restarts at address 0.
